// File: rtl/player_pos_ctrl_pkg.sv
// Shared constants, button indices, controller state type and position helpers
// for the player sprite position controller.
package player_pos_ctrl_pkg;

    localparam int unsigned POS_W  = 10;
    localparam int unsigned CALC_W = 11;
    localparam int unsigned BTN_W  = 5;
    localparam int unsigned CNT_W  = 16;

    localparam int unsigned H_VISIBLE      = 640;
    localparam int unsigned V_VISIBLE      = 480;
    localparam int unsigned PLAYER_HALF_W  = 10;
    localparam int unsigned PLAYER_HALF_H  = 20;
    localparam int unsigned PLAYER_STEP    = 2;
    localparam int unsigned PLAYER_START_X = 320;
    localparam int unsigned PLAYER_START_Y = 400;

    localparam int unsigned BTN_UP     = 0;
    localparam int unsigned BTN_DOWN   = 1;
    localparam int unsigned BTN_LEFT   = 2;
    localparam int unsigned BTN_RIGHT  = 3;
    localparam int unsigned BTN_CENTER = 4;

    typedef enum logic [1:0] {S_WAIT, S_CALC, S_COMMIT} ctrl_state_t;

    // One axis step: dec-only moves down, inc-only moves up, both/neither hold.
    function automatic logic signed [CALC_W-1:0] step_axis(input logic [POS_W-1:0] pos,
                                                           input logic dec,
                                                           input logic inc);
        logic signed [CALC_W-1:0] p;
        logic signed [CALC_W-1:0] s;
        p = $signed({1'b0, pos});
        s = $signed(CALC_W'(PLAYER_STEP));
        if (dec && !inc) return p - s;
        if (inc && !dec) return p + s;
        return p;
    endfunction

    // Saturate a signed candidate onto [lo, hi].
    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [CALC_W-1:0] v,
                                                   input logic signed [CALC_W-1:0] lo,
                                                   input logic signed [CALC_W-1:0] hi);
        if (v < lo) return POS_W'(lo);
        if (v > hi) return POS_W'(hi);
        return POS_W'(v);
    endfunction

endpackage

// File: rtl/player_pos_ctrl_debounce.sv
// Single-bit button conditioner: two-flop synchroniser followed by a
// stability counter that flips the accepted level after a sustained change.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic pixel_clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_state
);
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync_q1;
    logic            sync_q2;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Counter only advances while the synced level disagrees with the accepted one.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            btn_state <= 1'b0;
        end else if (sync_q2 == btn_state) begin
            cnt <= '0;
        end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt       <= '0;
            btn_state <= sync_q2;
        end else begin
            cnt <= cnt + DB_W'(1);
        end
    end

endmodule

// File: rtl/player_pos_ctrl.sv
// Frame-synchronous player sprite position controller: debounced buttons,
// vsync edge detect, and a WAIT/CALC/COMMIT sequencer that commits outside video.
module player_pos_ctrl
    import player_pos_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter logic        VSYNC_ACTIVE    = 1'b1
) (
    input  logic             pixel_clk,
    input  logic             reset,
    input  logic             en,
    input  logic [BTN_W-1:0] btn_raw,
    input  logic             vsync,
    input  logic             video_on,
    output logic [POS_W-1:0] player_x,
    output logic [POS_W-1:0] player_y,
    output logic             pos_update,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [BTN_W-1:0] btn_state
);
    logic        vsync_q;
    logic        frame_tick_c;
    logic        calc_c;
    logic        commit_c;
    ctrl_state_t state;
    ctrl_state_t state_nxt;

    logic [POS_W-1:0] nx;
    logic [POS_W-1:0] ny;
    logic [POS_W-1:0] nx_c;
    logic [POS_W-1:0] ny_c;

    for (genvar i = 0; i < BTN_W; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .pixel_clk(pixel_clk),
            .reset    (reset),
            .btn_raw  (btn_raw[i]),
            .btn_state(btn_state[i])
        );
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) vsync_q <= ~VSYNC_ACTIVE;
        else       vsync_q <= vsync;
    end

    assign frame_tick_c = (vsync == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE);

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) state <= S_WAIT;
        else       state <= state_nxt;
    end

    // Ticks arriving outside S_WAIT are simply ignored.
    always_comb begin
        state_nxt = state;
        calc_c    = 1'b0;
        commit_c  = 1'b0;
        case (state)
            S_WAIT: begin
                if (frame_tick_c && en) state_nxt = S_CALC;
            end
            S_CALC: begin
                calc_c    = 1'b1;
                state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                if (!video_on) begin
                    commit_c  = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            default: state_nxt = S_WAIT;
        endcase
    end

    // Center recenters and overrides any direction.
    always_comb begin
        nx_c = POS_W'(PLAYER_START_X);
        ny_c = POS_W'(PLAYER_START_Y);
        if (!btn_state[BTN_CENTER]) begin
            nx_c = clamp_pos(step_axis(player_x, btn_state[BTN_LEFT], btn_state[BTN_RIGHT]),
                             $signed(CALC_W'(PLAYER_HALF_W)),
                             $signed(CALC_W'(H_VISIBLE - PLAYER_HALF_W)));
            ny_c = clamp_pos(step_axis(player_y, btn_state[BTN_UP], btn_state[BTN_DOWN]),
                             $signed(CALC_W'(PLAYER_HALF_H)),
                             $signed(CALC_W'(V_VISIBLE - PLAYER_HALF_H)));
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            nx         <= POS_W'(PLAYER_START_X);
            ny         <= POS_W'(PLAYER_START_Y);
            player_x   <= POS_W'(PLAYER_START_X);
            player_y   <= POS_W'(PLAYER_START_Y);
            pos_update <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            pos_update <= commit_c;
            if (calc_c) begin
                nx <= nx_c;
                ny <= ny_c;
            end
            if (commit_c) begin
                player_x  <= nx;
                player_y  <= ny;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_player_pos_ctrl.sv
// Randomised self-checking bench for player_pos_ctrl against a frame-level
// arithmetic model of the sprite position, commit timing and button levels.
module tb_player_pos_ctrl;

    logic        pixel_clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  btn_raw;
    logic        vsync;
    logic        video_on;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic        pos_update;
    logic [15:0] frame_cnt;
    logic [4:0]  btn_state;

    int errors = 0;
    int checks = 0;
    int mx, my, mcnt;
    logic [4:0] mbtn;

    player_pos_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .VSYNC_ACTIVE   (1'b1)
    ) dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .en        (en),
        .btn_raw   (btn_raw),
        .vsync     (vsync),
        .video_on  (video_on),
        .player_x  (player_x),
        .player_y  (player_y),
        .pos_update(pos_update),
        .frame_cnt (frame_cnt),
        .btn_state (btn_state)
    );

    always #20 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Frame-level reference: one move per committed frame.
    task automatic model_step();
        int dx, dy;
        if (mbtn[4]) begin
            mx = 320;
            my = 400;
        end else begin
            dx = (mbtn[3] ? 2 : 0) - (mbtn[2] ? 2 : 0);
            dy = (mbtn[1] ? 2 : 0) - (mbtn[0] ? 2 : 0);
            mx = clampi(mx + dx, 10, 630);
            my = clampi(my + dy, 20, 460);
        end
        mcnt = (mcnt + 1) & 16'hFFFF;
    endtask

    task automatic set_btn(input logic [4:0] b);
        @(negedge pixel_clk);
        btn_raw = b;
        repeat (12) @(negedge pixel_clk);
        check("btn_state", 32'(btn_state), 32'(b));
        mbtn = b;
    endtask

    // One vsync edge; video_on held for vis edges; optional second tick while committing.
    task automatic frame(input int vis, input bit extra_tick);
        int  ox, oy, ocnt, ce;
        bit  commit;
        ox = mx; oy = my; ocnt = mcnt;
        commit = en;
        @(negedge pixel_clk);
        vsync    = 1'b1;
        video_on = (vis > 0);
        if (commit) model_step();
        ce = (vis + 1 > 3) ? vis + 1 : 3;
        for (int k = 1; k <= ce + 4; k++) begin
            @(posedge pixel_clk);
            #1;
            check("pos_update", 32'(pos_update), 32'(commit && k == ce));
            if (commit && k >= ce) begin
                check("player_x", 32'(player_x), 32'(mx));
                check("player_y", 32'(player_y), 32'(my));
                check("frame_cnt", 32'(frame_cnt), 32'(mcnt));
            end else begin
                check("player_x_hold", 32'(player_x), 32'(ox));
                check("player_y_hold", 32'(player_y), 32'(oy));
                check("frame_cnt_hold", 32'(frame_cnt), 32'(ocnt));
            end
            @(negedge pixel_clk);
            if (k == vis) video_on = 1'b0;
            if (extra_tick) vsync = (k == 2);
            else if (k == 1) vsync = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_x"}, 32'(player_x), 32'd320);
        check({tag, "_y"}, 32'(player_y), 32'd400);
        check({tag, "_cnt"}, 32'(frame_cnt), 32'd0);
        check({tag, "_upd"}, 32'(pos_update), 32'd0);
        check({tag, "_btn"}, 32'(btn_state), 32'd0);
    endtask

    initial begin
        int vis, r;
        logic [4:0] b;
        reset = 1'b1; en = 1'b1; btn_raw = '0; vsync = 1'b0; video_on = 1'b0;
        mx = 320; my = 400; mcnt = 0; mbtn = '0;
        repeat (3) @(negedge pixel_clk);
        check_reset_values("por");
        reset = 1'b0;

        // Right held for three frames.
        set_btn(5'b01000);
        for (int i = 1; i <= 3; i++) begin
            frame(0, 1'b0);
            check("right_walk_x", 32'(player_x), 32'(320 + 2 * i));
        end
        check("right_walk_cnt", 32'(frame_cnt), 32'd3);

        // Asynchronous reset while a commit is pending.
        @(negedge pixel_clk); vsync = 1'b1;
        @(negedge pixel_clk); vsync = 1'b0;
        @(posedge pixel_clk);
        #5 reset = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge pixel_clk); reset = 1'b0;
        mx = 320; my = 400; mcnt = 0; mbtn = '0;
        repeat (5) begin
            @(negedge pixel_clk);
            check("midrst_no_upd", 32'(pos_update), 32'd0);
        end
        set_btn(5'b00000);

        // Short glitch is rejected; sustained press is accepted.
        @(negedge pixel_clk); btn_raw = 5'b01000;
        repeat (5) @(negedge pixel_clk);
        btn_raw = 5'b00000;
        repeat (12) @(negedge pixel_clk);
        check("glitch_btn", 32'(btn_state), 32'd0);
        frame(0, 1'b0);
        btn_raw = 5'b01000;
        repeat (7) @(negedge pixel_clk);
        check("hold7_btn", 32'(btn_state), 32'd0);
        repeat (5) @(negedge pixel_clk);
        check("hold12_btn", 32'(btn_state), 32'd8);
        mbtn = 5'b01000;
        frame(0, 1'b0);

        // Opposing directions cancel; center overrides.
        set_btn(5'b01111);
        frame(0, 1'b0);
        set_btn(5'b10001);
        frame(0, 1'b0);
        check("center_x", 32'(player_x), 32'd320);
        check("center_y", 32'(player_y), 32'd400);

        // Disabled frames, deferred commit, and tick dropped while committing.
        set_btn(5'b01000);
        @(negedge pixel_clk); en = 1'b0;
        frame(0, 1'b0);
        frame(0, 1'b0);
        check("en0_cnt", 32'(frame_cnt), 32'(mcnt));
        @(negedge pixel_clk); en = 1'b1;
        frame(5, 1'b1);

        // Left edge clamp.
        set_btn(5'b10000);
        frame(0, 1'b0);
        set_btn(5'b00100);
        while (mx > 14) frame(0, 1'b0);
        check("left_start_x", 32'(player_x), 32'd14);
        frame(0, 1'b0); check("left_x0", 32'(player_x), 32'd12);
        frame(0, 1'b0); check("left_x1", 32'(player_x), 32'd10);
        frame(0, 1'b0); check("left_x2", 32'(player_x), 32'd10);

        // Bottom edge clamp.
        set_btn(5'b10000);
        frame(0, 1'b0);
        set_btn(5'b00010);
        while (my < 458) frame(0, 1'b0);
        check("down_start_y", 32'(player_y), 32'd458);
        frame(0, 1'b0); check("down_y0", 32'(player_y), 32'd460);
        frame(0, 1'b0); check("down_y1", 32'(player_y), 32'd460);

        // Random buttons, enable and visible-area holds.
        for (int i = 0; i < 40; i++) begin
            b = 5'($urandom_range(0, 31));
            if (b[4] && $urandom_range(0, 3) != 0) b[4] = 1'b0;
            set_btn(b);
            @(negedge pixel_clk);
            en = ($urandom_range(0, 7) != 0);
            r = int'($urandom_range(0, 3));
            vis = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 3 : 6;
            frame(vis, (vis >= 3) && ($urandom_range(0, 1) == 1));
            en = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
